// File: rtl/uart_core.sv
// 8N1 UART transceiver with a fixed bit period of CLKS_PER_BIT clocks.
// TX serialises CPU writes; RX deserialises into a single-byte holding register.
module uart_core #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_wr,
  input  logic [7:0] uart_w,
  output logic       uart_busy,
  input  logic       uart_rd,
  output logic       uart_valid,
  output logic [7:0] uart_data,
  output logic       uart_overrun,
  output logic       uart_ferr,
  output logic       tx,
  input  logic       rx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAITHI} rx_state_t;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_p0;
  logic             rs;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx        <= 1'b1;
      uart_busy <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (uart_wr) begin
            tx_shift  <= uart_w;
            tx_cnt    <= '0;
            tx        <= 1'b0;
            uart_busy <= 1'b1;
            tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == CNT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx       <= tx_shift[1];
              tx_bit   <= tx_bit + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          // Stop level stays on tx as the idle level once busy drops.
          if (tx_cnt == CNT_LAST) begin
            tx_cnt    <= '0;
            uart_busy <= 1'b0;
            tx_state  <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Stage p0 -> rs: two-flop synchroniser for the asynchronous rx pin
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rs    <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rs    <= rx_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      uart_valid   <= 1'b0;
      uart_data    <= '0;
      uart_overrun <= 1'b0;
      uart_ferr    <= 1'b0;
    end else begin
      uart_ferr <= 1'b0;
      if (uart_rd && uart_valid) begin
        uart_valid   <= 1'b0;
        uart_overrun <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (!rs) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == CNT_HALF) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rs ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rs, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_LAST) begin
            rx_cnt <= '0;
            if (rs) begin
              // A load overrides a same-cycle read; that read consumed the old byte.
              uart_data    <= rx_shift;
              uart_valid   <= 1'b1;
              uart_overrun <= uart_valid && !uart_rd;
              rx_state     <= RX_IDLE;
            end else begin
              uart_ferr <= 1'b1;
              rx_state  <= RX_WAITHI;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAITHI: begin
          if (rs) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: TX waveform vectors, RX holding-register vectors,
// break/glitch/reset sequences and tx->rx loopback.
module tb_uart_core;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_wr;
  logic [7:0] uart_w;
  logic       uart_busy;
  logic       uart_rd;
  logic       uart_valid;
  logic [7:0] uart_data;
  logic       uart_overrun;
  logic       uart_ferr;
  logic       tx;
  logic       rx_drv;
  logic       loop_en;
  wire        rx;

  int errors = 0;
  int checks = 0;
  int ferr_cnt = 0;
  int f0;

  assign rx = loop_en ? tx : rx_drv;

  uart_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .uart_wr(uart_wr), .uart_w(uart_w),
    .uart_busy(uart_busy), .uart_rd(uart_rd), .uart_valid(uart_valid),
    .uart_data(uart_data), .uart_overrun(uart_overrun), .uart_ferr(uart_ferr),
    .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (uart_ferr) ferr_cnt <= ferr_cnt + 1;

  typedef struct {
    logic [7:0] b;
    logic [9:0] frame;
    int         inject;
  } tx_vec_t;

  typedef struct {
    logic [7:0] b;
    int         rd_cyc;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ov;
    logic       rd_after;
  } rx_vec_t;

  tx_vec_t txv[3];
  rx_vec_t rxv[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called on a negedge with busy low; returns on the first negedge with busy low again.
  task automatic tx_frame(input logic [7:0] b, input logic [9:0] frame, input int inject);
    uart_w  = b;
    uart_wr = 1'b1;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      uart_wr = 1'b0;
      if (i == inject) begin
        uart_wr = 1'b1;
        uart_w  = 8'hAA;
      end
      chk("tx_level", tx, frame[i / CPB]);
      chk("tx_busy", uart_busy, 1);
    end
    @(negedge clk);
    chk("tx_busy_end", uart_busy, 0);
    chk("tx_idle", tx, 1);
  endtask

  task automatic rx_send(input logic [7:0] b, input int stop_low, input int rd_cyc);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      rx_drv  = (c >= 9 * CPB && stop_low > 0) ? 1'b0 : f[c / CPB];
      uart_rd = (c == rd_cyc);
      @(negedge clk);
    end
    uart_rd = 1'b0;
    if (stop_low > 0) begin
      repeat (stop_low - CPB) @(negedge clk);
      rx_drv = 1'b1;
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  initial begin
    txv[0] = '{8'h55, 10'b1_01010101_0, -1};
    txv[1] = '{8'h55, 10'b1_01010101_0, 20};
    txv[2] = '{8'h3C, 10'b1_00111100_0, -1};

    // Load sampled 155 clocks after the start bit is driven; rd_cyc 154 lands on that cycle.
    rxv[0] = '{8'hA5, -1,  1'b1, 8'hA5, 1'b0, 1'b1};
    rxv[1] = '{8'h11, -1,  1'b1, 8'h11, 1'b0, 1'b0};
    rxv[2] = '{8'h22, -1,  1'b1, 8'h22, 1'b1, 1'b0};
    rxv[3] = '{8'h33, 154, 1'b1, 8'h33, 1'b0, 1'b1};

    reset = 1'b1; uart_wr = 1'b0; uart_w = 8'h00; uart_rd = 1'b0;
    rx_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", uart_busy, 0);
    chk("rst_valid", uart_valid, 0);
    chk("rst_data", uart_data, 0);
    chk("rst_overrun", uart_overrun, 0);
    chk("rst_ferr", uart_ferr, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 3; v++) tx_frame(txv[v].b, txv[v].frame, txv[v].inject);

    for (int v = 0; v < 4; v++) begin
      rx_send(rxv[v].b, 0, rxv[v].rd_cyc);
      chk("rx_valid", uart_valid, rxv[v].exp_valid);
      chk("rx_data", uart_data, rxv[v].exp_data);
      chk("rx_overrun", uart_overrun, rxv[v].exp_ov);
      if (rxv[v].rd_after) begin
        uart_rd = 1'b1;
        @(negedge clk);
        uart_rd = 1'b0;
        chk("rd_valid", uart_valid, 0);
        chk("rd_overrun", uart_overrun, 0);
        chk("rd_data_hold", uart_data, rxv[v].exp_data);
      end
    end

    uart_rd = 1'b1;
    @(negedge clk);
    uart_rd = 1'b0;
    @(negedge clk);
    chk("rd_empty_valid", uart_valid, 0);
    chk("rd_empty_data", uart_data, 8'h33);

    f0 = ferr_cnt;
    rx_send(8'h7E, 40 * CPB, -1);
    chk("break_ferr_pulses", ferr_cnt - f0, 1);
    chk("break_valid", uart_valid, 0);
    chk("break_data", uart_data, 8'h33);
    rx_send(8'h01, 0, -1);
    chk("after_break_valid", uart_valid, 1);
    chk("after_break_data", uart_data, 8'h01);
    chk("after_break_ferr", ferr_cnt - f0, 1);
    uart_rd = 1'b1;
    @(negedge clk);
    uart_rd = 1'b0;

    f0 = ferr_cnt;
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    chk("glitch_valid", uart_valid, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);

    uart_w = 8'hC3; uart_wr = 1'b1;
    @(negedge clk);
    uart_wr = 1'b0;
    chk("midrst_busy_before", uart_busy, 1);
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", uart_busy, 0);
    repeat (2 * CPB) @(negedge clk);
    chk("midrst_tx_quiet", tx, 1);
    chk("midrst_busy_quiet", uart_busy, 0);

    loop_en = 1'b1;
    tx_frame(8'h00, 10'b1_00000000_0, -1);
    chk("loop00_valid", uart_valid, 1);
    chk("loop00_data", uart_data, 8'h00);
    uart_rd = 1'b1;
    @(negedge clk);
    uart_rd = 1'b0;
    tx_frame(8'hFF, 10'b1_11111111_0, -1);
    chk("loopFF_valid", uart_valid, 1);
    chk("loopFF_data", uart_data, 8'hFF);
    chk("loopFF_overrun", uart_overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
